// File: rtl/button_debounce_pulse.sv
// Start/stop push-button conditioner: two-flop synchronizer, per-channel debounce FSM,
// and a registered one-cycle press pulse per channel with start taking priority.

module button_debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic clk_50MHz,
  input  logic rst,
  input  logic sample,
  output logic held,
  output logic press_req
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  state_t               state_r;
  state_t               state_s;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic [CNT_WIDTH-1:0] cnt_s;
  logic                 req_s;
  logic                 held_r;
  logic                 req_r;

  // Next-state, counter and pulse-request decode.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    req_s   = 1'b0;
    case (state_r)
      RELEASED: begin
        if (sample) begin
          state_s = PRESS_WAIT;
          cnt_s   = CNT_ONE;
        end else begin
          state_s = RELEASED;
          cnt_s   = CNT_ZERO;
        end
      end
      PRESS_WAIT: begin
        if (!sample) begin
          state_s = RELEASED;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_MAX) begin
          state_s = PRESSED;
          cnt_s   = CNT_ZERO;
          req_s   = 1'b1;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!sample) begin
          state_s = RELEASE_WAIT;
          cnt_s   = CNT_ONE;
        end else begin
          state_s = PRESSED;
          cnt_s   = CNT_ZERO;
        end
      end
      RELEASE_WAIT: begin
        // A high sample here is release bounce: back to PRESSED without a new request.
        if (sample) begin
          state_s = PRESSED;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_MAX) begin
          state_s = RELEASED;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = RELEASED;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter, held level and request registers.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state_r <= RELEASED;
      cnt_r   <= CNT_ZERO;
      held_r  <= 1'b0;
      req_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      held_r  <= (state_s == PRESSED) || (state_s == RELEASE_WAIT);
      req_r   <= req_s;
    end
  end

  assign held      = held_r;
  assign press_req = req_r;

endmodule

module button_debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic clk_50MHz,
  input  logic rst,
  input  logic btn_start_raw,
  input  logic btn_stop_raw,
  output logic result_start,
  output logic result_stop,
  output logic start_held,
  output logic stop_held
);

  logic [1:0] s1_r;
  logic [1:0] s2_r;
  logic       start_req_s;
  logic       stop_req_s;
  logic       result_start_r;
  logic       result_stop_r;

  button_debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_start (
    .clk_50MHz(clk_50MHz),
    .rst      (rst),
    .sample   (s2_r[0]),
    .held     (start_held),
    .press_req(start_req_s)
  );

  button_debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_stop (
    .clk_50MHz(clk_50MHz),
    .rst      (rst),
    .sample   (s2_r[1]),
    .held     (stop_held),
    .press_req(stop_req_s)
  );

  // Synchronizer flops and pulse outputs; a stop request coinciding with start is dropped.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      s1_r           <= 2'b00;
      s2_r           <= 2'b00;
      result_start_r <= 1'b0;
      result_stop_r  <= 1'b0;
    end else begin
      s1_r           <= {btn_stop_raw, btn_start_raw};
      s2_r           <= s1_r;
      result_start_r <= start_req_s;
      result_stop_r  <= stop_req_s & ~start_req_s;
    end
  end

  assign result_start = result_start_r;
  assign result_stop  = result_stop_r;

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Self-checking bench for button_debounce_pulse: directed latency scenarios plus
// randomized button activity checked against a run-length reference model.

module tb_button_debounce_pulse;

  localparam int D = 4;

  logic clk_50MHz = 1'b0;
  logic rst = 1'b0;
  logic btn_start_raw = 1'b0;
  logic btn_stop_raw = 1'b0;
  logic result_start;
  logic result_stop;
  logic start_held;
  logic stop_held;

  int checks = 0;
  int failures = 0;

  // Reference model: debounced level flips after D consecutive synchronized samples that disagree with it.
  logic [1:0] m_s1 = 2'b00;
  logic [1:0] m_s2 = 2'b00;
  logic [1:0] m_held = 2'b00;
  logic [1:0] m_req = 2'b00;
  int         m_run [2] = '{0, 0};
  logic       m_res_start = 1'b0;
  logic       m_res_stop = 1'b0;

  button_debounce_pulse #(.DEBOUNCE_CYCLES(D), .CNT_WIDTH(3)) dut (
    .clk_50MHz    (clk_50MHz),
    .rst          (rst),
    .btn_start_raw(btn_start_raw),
    .btn_stop_raw (btn_stop_raw),
    .result_start (result_start),
    .result_stop  (result_stop),
    .start_held   (start_held),
    .stop_held    (stop_held)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  task automatic model_step(input logic rr, input logic [1:0] rw);
    if (rr) begin
      m_s1 = 2'b00; m_s2 = 2'b00; m_held = 2'b00; m_req = 2'b00;
      m_run[0] = 0; m_run[1] = 0;
      m_res_start = 1'b0; m_res_stop = 1'b0;
    end else begin
      m_res_start = m_req[0];
      m_res_stop  = m_req[1] & ~m_req[0];
      for (int ch = 0; ch < 2; ch++) begin
        m_req[ch] = 1'b0;
        if (m_s2[ch] != m_held[ch]) begin
          m_run[ch] = m_run[ch] + 1;
          if (m_run[ch] == D) begin
            m_held[ch] = m_s2[ch];
            m_run[ch]  = 0;
            m_req[ch]  = m_s2[ch];
          end
        end else begin
          m_run[ch] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = rw;
    end
  endtask

  task automatic tick();
    logic rr;
    logic [1:0] rw;
    rr = rst;
    rw = {btn_stop_raw, btn_start_raw};
    @(posedge clk_50MHz);
    model_step(rr, rw);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; btn_start_raw = 1'b0; btn_stop_raw = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_start_raw = 1'b1; btn_stop_raw = 1'b1;
    tick();
    checks++;
    if ({result_start, result_stop, start_held, stop_held} !== 4'b0000) begin
      failures++;
      $display("FAIL reset got=%b want=0000", {result_start, result_stop, start_held, stop_held});
    end
    rst = 1'b0; btn_start_raw = 1'b0; btn_stop_raw = 1'b0;
  endtask

  task automatic test_clean_press();
    do_reset();
    btn_start_raw = 1'b1;
    for (int e = 0; e < 57; e++) begin
      tick();
      checks++;
      if ({result_start, start_held, result_stop} !== {(e == 6), (e >= 5), 1'b0}) begin
        failures++;
        $display("FAIL clean_press e=%0d got p=%b h=%b stop=%b want p=%b h=%b stop=0",
                 e, result_start, start_held, result_stop, (e == 6), (e >= 5));
      end
    end
    btn_start_raw = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      checks++;
      if ({result_start, start_held} !== {1'b0, (e < 5)}) begin
        failures++;
        $display("FAIL clean_release e=%0d got p=%b h=%b want p=0 h=%b", e, result_start, start_held, (e < 5));
      end
    end
  endtask

  task automatic test_bounce();
    logic [13:0] pat;
    int pulses;
    pat = 14'b11101110000000;
    do_reset();
    for (int e = 0; e < 14; e++) begin
      btn_start_raw = pat[13-e];
      tick();
      checks++;
      if ({result_start, start_held} !== 2'b00) begin
        failures++;
        $display("FAIL bounce_reject e=%0d got p=%b h=%b want p=0 h=0", e, result_start, start_held);
      end
    end
    pulses = 0;
    for (int e = 0; e < 16; e++) begin
      btn_start_raw = (e < 4);
      tick();
      if (result_start === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL bounce_qualify got pulses=%0d want 1", pulses);
    end
  endtask

  task automatic test_release_bounce();
    int pulses;
    do_reset();
    btn_start_raw = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      checks++;
      if ({result_start, start_held} !== {(e == 6), (e >= 5)}) begin
        failures++;
        $display("FAIL rel_bounce_press e=%0d got p=%b h=%b want p=%b h=%b",
                 e, result_start, start_held, (e == 6), (e >= 5));
      end
    end
    for (int e = 0; e < 10; e++) begin
      btn_start_raw = (e >= 2);
      tick();
      checks++;
      if ({result_start, start_held} !== 2'b01) begin
        failures++;
        $display("FAIL rel_bounce_hold e=%0d got p=%b h=%b want p=0 h=1", e, result_start, start_held);
      end
    end
    btn_start_raw = 1'b0;
    for (int e = 0; e < 8; e++) tick();
    checks++;
    if (start_held !== 1'b0) begin
      failures++;
      $display("FAIL rel_bounce_release got h=%b want 0", start_held);
    end
    pulses = 0;
    btn_start_raw = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (result_start === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL rel_bounce_repress got pulses=%0d want 1", pulses);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    btn_start_raw = 1'b1; btn_stop_raw = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      checks++;
      if ({result_start, result_stop, start_held, stop_held} !== {(e == 6), 1'b0, (e >= 5), (e >= 5)}) begin
        failures++;
        $display("FAIL simultaneous e=%0d got ps=%b pp=%b hs=%b hp=%b want ps=%b pp=0 hs=%b hp=%b",
                 e, result_start, result_stop, start_held, stop_held, (e == 6), (e >= 5), (e >= 5));
      end
    end
  endtask

  task automatic test_offset();
    do_reset();
    btn_start_raw = 1'b1;
    for (int e = 0; e < 12; e++) begin
      if (e == 1) btn_stop_raw = 1'b1;
      tick();
      checks++;
      if ({result_start, result_stop, start_held, stop_held} !== {(e == 6), (e == 7), (e >= 5), (e >= 6)}) begin
        failures++;
        $display("FAIL offset e=%0d got ps=%b pp=%b hs=%b hp=%b want ps=%b pp=%b hs=%b hp=%b",
                 e, result_start, result_stop, start_held, stop_held, (e == 6), (e == 7), (e >= 5), (e >= 6));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    btn_stop_raw = 1'b1;
    for (int e = 0; e < 3; e++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({result_start, result_stop, start_held, stop_held} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid_clear got=%b want=0000", {result_start, result_stop, start_held, stop_held});
    end
    rst = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      checks++;
      if ({result_start, result_stop, stop_held} !== {1'b0, (e == D + 2), (e >= D + 1)}) begin
        failures++;
        $display("FAIL reset_mid_repress e=%0d got ps=%b pp=%b hp=%b want ps=0 pp=%b hp=%b",
                 e, result_start, result_stop, stop_held, (e == D + 2), (e >= D + 1));
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] lv;
    lv = 2'b00;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int ch = 0; ch < 2; ch++) begin
        if ($urandom_range(0, 4) == 0) lv[ch] = ~lv[ch];
      end
      btn_start_raw = lv[0];
      btn_stop_raw  = lv[1];
      tick();
      checks++;
      if ({result_start, result_stop, start_held, stop_held} !== {m_res_start, m_res_stop, m_held[0], m_held[1]}) begin
        failures++;
        $display("FAIL random i=%0d got ps=%b pp=%b hs=%b hp=%b want ps=%b pp=%b hs=%b hp=%b",
                 i, result_start, result_stop, start_held, stop_held,
                 m_res_start, m_res_stop, m_held[0], m_held[1]);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    #5;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_simultaneous();
    test_offset();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_debounce_pulse.md
# button_debounce_pulse

Dual-channel push-button conditioner. It synchronizes the raw start and stop buttons to `clk_50MHz` and debounces each one with its own counter-based state machine. It emits a one-cycle `result_start` / `result_stop` pulse on each qualified press. It is the producer side of the debounced-button interface and feeds the start/stop state-holding logic directly.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive synchronized samples required to qualify a press or a release (20 ms at 50 MHz). Legal range 2 to 2^`CNT_WIDTH`.
- `CNT_WIDTH`, default 20: debounce counter width.
- `clk_50MHz`  input  1  system clock. Single clock domain.
- `rst`  input  1  synchronous, active-high reset.
- `btn_start_raw`  input  1  raw start button, asynchronous, active-high.
- `btn_stop_raw`  input  1  raw stop button, asynchronous, active-high.
- `result_start`  output  1  one-cycle pulse per qualified start press.
- `result_stop`  output  1  one-cycle pulse per qualified stop press.
- `start_held`  output  1  debounced start level.
- `stop_held`  output  1  debounced stop level.

## Operation
- Synchronizer: each raw input passes through two flops (`s1`, `s2`). All debounce logic uses `s2` only.
- Each channel has an identical FSM with states RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus a counter `cnt`.
- RELEASED:
  - `s2`=1 → PRESS_WAIT, `cnt`=1.
- PRESS_WAIT:
  - `s2`=0 → RELEASED, `cnt`=0 (glitch rejected, no pulse).
  - `s2`=1 and `cnt`=DEBOUNCE_CYCLES-1 → PRESSED, `cnt`=0, raw pulse request.
  - Otherwise `cnt`+1.
- PRESSED:
  - `s2`=0 → RELEASE_WAIT, `cnt`=1.
- RELEASE_WAIT:
  - `s2`=1 → PRESSED, `cnt`=0 (bounce during release; no new pulse).
  - `s2`=0 and `cnt`=DEBOUNCE_CYCLES-1 → RELEASED, `cnt`=0.
  - Otherwise `cnt`+1.
- `*_held` = 1 in PRESSED and RELEASE_WAIT, 0 otherwise.
- Pulse outputs are registered.
  - `result_start` is high for exactly the cycle after the start FSM enters PRESSED.
  - `result_stop` follows the same rule for the stop FSM.
- Simultaneous qualification:
  - If both channels request a pulse on the same edge, only `result_start` asserts.
  - The stop pulse is dropped, not deferred. `stop_held` still rises normally.
- Holding a button never retriggers. A new pulse requires a full qualified release followed by a full qualified press.
- The counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.

## Timing
- Reset: synchronous on `rst`=1 at a rising edge.
  - `s1`, `s2`, `cnt` = 0; both FSMs go to RELEASED.
  - `result_start`, `result_stop`, `start_held`, `stop_held` = 0.
- Reset mid-operation aborts any pending qualification with no pulse.
- A button still held after `rst` deasserts is treated as a new press and pulses after the full latency.
- Press latency:
  - Edge E0 is the first edge at which raw is sampled high.
  - With raw held high, `s2` is high after edge E0+1 and PRESSED is entered at edge E0+1+DEBOUNCE_CYCLES.
  - The pulse is high after edge E0+2+DEBOUNCE_CYCLES, for one cycle.
- `*_held` rises one edge before the corresponding pulse.
- Release latency: `*_held` falls at edge E0+1+DEBOUNCE_CYCLES after the first edge sampling raw low.
- Glitches: a high run of DEBOUNCE_CYCLES-1 or fewer synchronized samples produces no pulse and leaves `*_held`=0.

## Test plan
Benches use DEBOUNCE_CYCLES=4, CNT_WIDTH=3.
- Clean press: raw start high from edge 0 and held.
  - `start_held`=1 after edge 5.
  - `result_start`=1 after edge 6 only.
  - No further pulses while held for 50 cycles.
- Bounce rejection: raw start high 3 cycles, low 1, high 3, low.
  - No pulse and `start_held` stays 0.
  - Then a 4-cycle high run produces exactly one pulse.
- Release bounce: while pressed, raw low 2 cycles then high again.
  - `start_held` stays 1 and no new pulse.
  - A later low of 4 or more cycles followed by a clean press gives exactly one new pulse.
- Simultaneous: both raw buttons rise on the same edge.
  - `result_start` pulses after edge 6 and `result_stop` stays 0 throughout.
  - Both `*_held`=1 after edge 5.
- Stop offset by one cycle: stop rises 1 edge after start.
  - `result_start` pulses after edge 6 and `result_stop` pulses after edge 7.
- Reset mid-operation: assert `rst` for 1 cycle during PRESS_WAIT with raw stop held.
  - All outputs 0 after the reset edge.
  - `result_stop` pulses DEBOUNCE_CYCLES+2 edges after the first post-reset edge.
